// File: rtl/issue_scheduler_pkg.sv
// Shared types and defaults for the issue-side scheduler.
package issue_scheduler_pkg;

  localparam int SCHED_LAT_W    = 3;
  localparam int SCHED_NUM_ROWS = 8;

  typedef enum logic [1:0] {
    ROW_FREE = 2'd0,
    ROW_WAIT = 2'd1,
    ROW_EXEC = 2'd2
  } sched_row_state_e;

endpackage

// File: rtl/issue_scheduler_rr_arbiter.sv
// Round-robin arbiter: scans requests starting at a rotating pointer and
// grants the first one found. The pointer moves past the winner on advance.
// Used by issue_scheduler only when SCHED_RR_SELECT_EN is defined.
module rr_arbiter #(
  parameter  int N    = 8,
  localparam int IW   = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_index
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] idx;
  logic          found;

  // First request at or after the pointer, wrapping modulo N (N is a power of two)
  always_comb begin
    grant       = '0;
    grant_index = '0;
    found       = 1'b0;
    idx         = '0;
    for (int off = 0; off < N; off++) begin
      idx = ptr_q + IW'(off);
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant_index = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

  // Pointer moves one past the granted row when the grant is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= grant_index + IW'(1);
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Issue-side controller downstream of the dependency matrix: tracks row
// allocation, issues one ready row per cycle, frees the issued row's matrix
// entry and broadcasts its wakeup once the execution latency has elapsed.
// Build option: SCHED_RR_SELECT_EN selects round-robin issue selection;
// without it the lowest-index candidate wins.
//
// Per-row state table:
//   state    | meaning
//   ROW_FREE | row allocatable, no instruction held
//   ROW_WAIT | allocated, waiting for ready_vector and an issue slot
//   ROW_EXEC | issued, cnt_q counting down the execution latency
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter  int NUM_ROWS = SCHED_NUM_ROWS,
  parameter  int LAT_W    = SCHED_LAT_W,
  localparam int IDX_W    = $clog2(NUM_ROWS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_en,
  input  logic [IDX_W-1:0]    alloc_row_index,
  input  logic [LAT_W-1:0]    alloc_latency,
  input  logic [NUM_ROWS-1:0] ready_vector,
  input  logic                issue_ready,
  output logic                issue_valid,
  output logic [IDX_W-1:0]    issue_row_index,
  output logic                free_en,
  output logic [IDX_W-1:0]    free_row_index,
  output logic                clear_en,
  output logic [NUM_ROWS-1:0] clear_lines,
  output logic [NUM_ROWS-1:0] row_busy
);

  sched_row_state_e    state_q [NUM_ROWS];
  sched_row_state_e    state_d [NUM_ROWS];
  logic [LAT_W-1:0]    cnt_q   [NUM_ROWS];
  logic [LAT_W-1:0]    cnt_d   [NUM_ROWS];
  logic [NUM_ROWS-1:0] cand;
  logic [NUM_ROWS-1:0] sel;
  logic [IDX_W-1:0]    sel_index;
  logic [NUM_ROWS-1:0] clear_d;
  logic [NUM_ROWS-1:0] clear_q;
  logic                hs;
  logic                free_en_q;
  logic [IDX_W-1:0]    free_idx_q;

  // Issue candidates: waiting rows the matrix reports as dependence-free
  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      cand[i] = (state_q[i] == ROW_WAIT) && ready_vector[i];
    end
  end

  assign issue_valid     = |cand;
  assign hs              = issue_valid && issue_ready;
  assign issue_row_index = sel_index;

`ifdef SCHED_RR_SELECT_EN
  rr_arbiter #(.N(NUM_ROWS)) u_rr_arbiter (
    .clk         (clk),
    .rst         (rst),
    .req         (cand),
    .advance     (hs),
    .grant       (sel),
    .grant_index (sel_index)
  );
`else
  // Fixed priority: descending scan so the lowest candidate index ends up selected
  always_comb begin
    sel       = '0;
    sel_index = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel       = '0;
        sel[i]    = 1'b1;
        sel_index = IDX_W'(i);
      end
    end
  end
`endif

  // Per-row next state. The wakeup pulse is registered, so the row goes FREE
  // on the same edge that raises clear_lines; the countdown therefore ends at
  // 1 and a zero-latency row skips EXEC entirely.
  always_comb begin
    clear_d = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ROW_FREE: begin
          if (alloc_en && (alloc_row_index == IDX_W'(i))) begin
            state_d[i] = ROW_WAIT;
            cnt_d[i]   = alloc_latency;
          end
        end
        ROW_WAIT: begin
          if (hs && sel[i]) begin
            if (cnt_q[i] == '0) begin
              state_d[i] = ROW_FREE;
              clear_d[i] = 1'b1;
            end else begin
              state_d[i] = ROW_EXEC;
            end
          end
        end
        ROW_EXEC: begin
          if (cnt_q[i] == LAT_W'(1)) begin
            state_d[i] = ROW_FREE;
            cnt_d[i]   = '0;
            clear_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - LAT_W'(1);
          end
        end
        default: state_d[i] = ROW_FREE;
      endcase
    end
  end

  // State, counters and the registered free/clear outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ROWS; i++) begin
        state_q[i] <= ROW_FREE;
        cnt_q[i]   <= '0;
      end
      clear_q    <= '0;
      free_en_q  <= 1'b0;
      free_idx_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ROWS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      clear_q   <= clear_d;
      free_en_q <= hs;
      if (hs) begin
        free_idx_q <= sel_index;
      end
    end
  end

  // Busy flags straight from registered state
  always_comb begin
    row_busy = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      row_busy[i] = (state_q[i] != ROW_FREE);
    end
  end

  assign free_en        = free_en_q;
  assign free_row_index = free_idx_q;
  assign clear_lines    = clear_q;
  assign clear_en       = |clear_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboard bench for issue_scheduler: directed stimulus pushes expected
// issue/free/clear events (value and cycle) and a negedge monitor pops them.
module tb_issue_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_en;
  logic [2:0] alloc_row_index;
  logic [2:0] alloc_latency;
  logic [7:0] ready_vector;
  logic       issue_ready;
  logic       issue_valid;
  logic [2:0] issue_row_index;
  logic       free_en;
  logic [2:0] free_row_index;
  logic       clear_en;
  logic [7:0] clear_lines;
  logic [7:0] row_busy;

  issue_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_en        (alloc_en),
    .alloc_row_index (alloc_row_index),
    .alloc_latency   (alloc_latency),
    .ready_vector    (ready_vector),
    .issue_ready     (issue_ready),
    .issue_valid     (issue_valid),
    .issue_row_index (issue_row_index),
    .free_en         (free_en),
    .free_row_index  (free_row_index),
    .clear_en        (clear_en),
    .clear_lines     (clear_lines),
    .row_busy        (row_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t q_issue[$];
  exp_t q_free[$];
  exp_t q_clear[$];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_issue(input int row, input int c);
    q_issue.push_back('{row, c});
  endtask

  task automatic exp_free(input int row, input int c);
    q_free.push_back('{row, c});
  endtask

  task automatic exp_clear(input int lines, input int c);
    q_clear.push_back('{lines, c});
  endtask

  task automatic do_alloc(input int row, input int lat);
    alloc_en        = 1'b1;
    alloc_row_index = 3'(row);
    alloc_latency   = 3'(lat);
  endtask

  // Monitor: every observed handshake, free and wakeup must match the next expectation
  always @(negedge clk) begin
    exp_t e;
    if (issue_valid && issue_ready) begin
      if (q_issue.size() == 0) chk("unexpected_issue", int'(issue_row_index), -1);
      else begin
        e = q_issue.pop_front();
        chk("issue_index", int'(issue_row_index), e.val);
        chk("issue_cycle", cyc, e.cyc);
      end
    end
    if (free_en) begin
      if (q_free.size() == 0) chk("unexpected_free", int'(free_row_index), -1);
      else begin
        e = q_free.pop_front();
        chk("free_index", int'(free_row_index), e.val);
        chk("free_cycle", cyc, e.cyc);
      end
    end
    if (clear_en || (clear_lines != 8'h00)) begin
      chk("clear_en_vs_lines", int'(clear_en), int'(|clear_lines));
      if (q_clear.size() == 0) chk("unexpected_clear", int'(clear_lines), -1);
      else begin
        e = q_clear.pop_front();
        chk("clear_lines", int'(clear_lines), e.val);
        chk("clear_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int first;
    int second;
    rst             = 1'b1;
    alloc_en        = 1'b0;
    alloc_row_index = '0;
    alloc_latency   = '0;
    ready_vector    = '0;
    issue_ready     = 1'b0;
    repeat (3) step();

    // Reset values
    chk("rst_issue_valid", int'(issue_valid), 0);
    chk("rst_issue_row_index", int'(issue_row_index), 0);
    chk("rst_free_en", int'(free_en), 0);
    chk("rst_free_row_index", int'(free_row_index), 0);
    chk("rst_clear_en", int'(clear_en), 0);
    chk("rst_clear_lines", int'(clear_lines), 0);
    chk("rst_row_busy", int'(row_busy), 0);
    rst = 1'b0;
    step();

    // Single row 3, latency 2
    c = cyc;
    do_alloc(3, 2);
    ready_vector = 8'h08;
    issue_ready  = 1'b1;
    chk("t1_no_issue_before_alloc", int'(issue_valid), 0);
    chk("t1_busy_before_alloc", int'(row_busy), 0);
    step();
    alloc_en = 1'b0;
    chk("t1_busy_wait", int'(row_busy), 8'h08);
    chk("t1_issue_valid", int'(issue_valid), 1);
    exp_issue(3, c + 1);
    exp_free(3, c + 2);
    exp_clear(8'h08, c + 4);
    repeat (2) step();
    chk("t1_busy_exec", int'(row_busy), 8'h08);
    step();
    chk("t1_busy_after_clear", int'(row_busy), 0);
    ready_vector = 8'h00;
    step();

    // Rows 1 and 5 held back by ready_vector
    c = cyc;
    do_alloc(1, 3);
    step();
    do_alloc(5, 0);
    step();
    alloc_en = 1'b0;
    chk("t2_busy", int'(row_busy), 8'h22);
    chk("t2_no_issue", int'(issue_valid), 0);
    step();
    chk("t2_still_no_issue", int'(issue_valid), 0);
    ready_vector = 8'h20;
    exp_issue(5, c + 3);
    exp_free(5, c + 4);
    exp_clear(8'h20, c + 4);
    step();
    ready_vector = 8'h00;
    chk("t2_busy_row1_only", int'(row_busy), 8'h02);
    repeat (2) step();
    c = cyc;
    ready_vector = 8'h02;
    exp_issue(1, c);
    exp_free(1, c + 1);
    exp_clear(8'h02, c + 4);
    step();
    ready_vector = 8'h00;
    repeat (5) step();

    // Reset so both selection schemes start from pointer 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Rows 0, 2, 6 ready together
    c = cyc;
    issue_ready = 1'b0;
    do_alloc(0, 1);
    step();
    do_alloc(2, 1);
    step();
    do_alloc(6, 1);
    step();
    alloc_en     = 1'b0;
    ready_vector = 8'h45;
    issue_ready  = 1'b1;
    exp_issue(0, c + 3);
    exp_issue(2, c + 4);
    exp_issue(6, c + 5);
    exp_free(0, c + 4);
    exp_free(2, c + 5);
    exp_free(6, c + 6);
    exp_clear(8'h01, c + 5);
    exp_clear(8'h04, c + 6);
    exp_clear(8'h40, c + 7);
    repeat (3) step();
    ready_vector = 8'h00;
    repeat (2) step();

    // Rows 1 and 7 ready together: order reveals the selection scheme
`ifdef SCHED_RR_SELECT_EN
    first  = 7;
    second = 1;
`else
    first  = 1;
    second = 7;
`endif
    c = cyc;
    issue_ready = 1'b0;
    do_alloc(1, 0);
    step();
    do_alloc(7, 0);
    step();
    alloc_en     = 1'b0;
    ready_vector = 8'h82;
    issue_ready  = 1'b1;
    exp_issue(first, c + 2);
    exp_issue(second, c + 3);
    exp_free(first, c + 3);
    exp_free(second, c + 4);
    exp_clear(1 << first, c + 3);
    exp_clear(1 << second, c + 4);
    repeat (2) step();
    ready_vector = 8'h00;
    repeat (2) step();

    // Row 1 (L=1) and row 4 (L=0) issued back-to-back clear together
    c = cyc;
    do_alloc(1, 1);
    step();
    do_alloc(4, 0);
    step();
    alloc_en     = 1'b0;
    ready_vector = 8'h02;
    exp_issue(1, c + 2);
    exp_free(1, c + 3);
    step();
    ready_vector = 8'h10;
    exp_issue(4, c + 3);
    exp_free(4, c + 4);
    exp_clear(8'h12, c + 4);
    step();
    ready_vector = 8'h00;
    chk("t4_clear_en", int'(clear_en), 1);
    repeat (2) step();

    // Back-pressure, plus an ignored alloc to the waiting row
    c = cyc;
    do_alloc(2, 1);
    ready_vector = 8'h04;
    issue_ready  = 1'b0;
    step();
    alloc_en = 1'b0;
    chk("t5_valid_stalled", int'(issue_valid), 1);
    chk("t5_index_stalled", int'(issue_row_index), 2);
    step();
    chk("t5_valid_still", int'(issue_valid), 1);
    chk("t5_no_free", int'(free_en), 0);
    chk("t5_busy", int'(row_busy), 8'h04);
    do_alloc(2, 3);
    step();
    alloc_en = 1'b0;
    chk("t5_busy_after_bad_alloc", int'(row_busy), 8'h04);
    issue_ready = 1'b1;
    exp_issue(2, c + 3);
    exp_free(2, c + 4);
    exp_clear(8'h04, c + 5);
    step();
    ready_vector = 8'h00;
    repeat (3) step();

    // Reset with two rows executing: nothing further may come out for them
    c = cyc;
    do_alloc(0, 7);
    step();
    do_alloc(3, 7);
    step();
    alloc_en     = 1'b0;
    ready_vector = 8'h01;
    exp_issue(0, c + 2);
    exp_free(0, c + 3);
    step();
    ready_vector = 8'h08;
    exp_issue(3, c + 3);
    exp_free(3, c + 4);
    step();
    ready_vector = 8'h00;
    chk("t6_busy_exec", int'(row_busy), 8'h09);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_issue_valid", int'(issue_valid), 0);
    chk("t6_free_en", int'(free_en), 0);
    chk("t6_clear_lines", int'(clear_lines), 0);
    chk("t6_row_busy", int'(row_busy), 0);
    repeat (12) step();

    chk("pending_issue", q_issue.size(), 0);
    chk("pending_free", q_free.size(), 0);
    chk("pending_clear", q_clear.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
